// File: rtl/fifo_pack_writer.sv
// Write-side packer for the dual-clock FIFO: packs RATIO narrow beats into one FIFO word.
// Optional idle-timeout flush of partial words is enabled by defining FIFO_PACK_TIMEOUT_EN.
module fifo_pack_writer #(
    parameter int unsigned         IN_WIDTH       = 16,
    parameter int unsigned         DATA_WIDTH     = 64,
    parameter int unsigned         RATIO          = 4,
    parameter logic [IN_WIDTH-1:0] PAD_VALUE      = 16'h0000,
    parameter int unsigned         TIMEOUT_CYCLES = 64
) (
    input  logic                  write_clk,
    input  logic                  write_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic                  s_last,
    output logic                  fifo_write_en,
    output logic [DATA_WIDTH-1:0] fifo_write_data,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_full,
    output logic [15:0]           word_count,
    output logic                  frame_done
);

    localparam int unsigned           LANE_W    = $clog2(RATIO);
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [DATA_WIDTH-1:0] PAD_WORD  = {RATIO{PAD_VALUE}};

    if (DATA_WIDTH != IN_WIDTH * RATIO || RATIO < 2 || RATIO > 16 ||
        (RATIO & (RATIO - 1)) != 0 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("fifo_pack_writer: invalid parameter combination");
    end

    logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_fill;
    logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [15:0]           word_count_q, word_count_d;
    logic                  frame_done_q, frame_done_d;

    logic write_ok;
    logic accept;
    logic close_word;
    logic flush;

    // Status inputs already include last cycle's write, so almost_full is the real guard.
    assign write_ok      = !fifo_full && !fifo_almost_full;
    assign fifo_write_en = out_valid_q && write_ok;

    // A last beat in a flush cycle would need a second output slot, so it is held off.
    assign s_ready    = write_rst_n && (!out_valid_q || write_ok) && !(flush && s_last);
    assign accept     = s_valid && s_ready;
    assign close_word = accept && ((lane_cnt_q == LAST_LANE) || s_last);

    assign fifo_write_data = out_data_q;
    assign word_count      = word_count_q;
    assign frame_done      = frame_done_q;

`ifdef FIFO_PACK_TIMEOUT_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;

    assign flush = (lane_cnt_q != '0) && (idle_cnt_q >= 16'(TIMEOUT_CYCLES)) && !out_valid_q;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (accept || flush || lane_cnt_q == '0) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q < 16'(TIMEOUT_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        acc_fill = acc_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane_cnt_q == LANE_W'(i)) begin
                acc_fill[i*IN_WIDTH +: IN_WIDTH] = s_data;
            end
        end
    end

    always_comb begin
        acc_d        = acc_q;
        lane_cnt_d   = lane_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !fifo_write_en;
        out_last_d   = out_last_q;
        word_count_d = word_count_q + {15'b0, fifo_write_en};
        frame_done_d = fifo_write_en && out_last_q;

        if (flush) begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            acc_d       = PAD_WORD;
            lane_cnt_d  = '0;
            if (accept) begin
                acc_d[IN_WIDTH-1:0] = s_data;
                lane_cnt_d          = LANE_W'(1);
            end
        end else if (close_word) begin
            out_data_d  = acc_fill;
            out_valid_d = 1'b1;
            out_last_d  = s_last;
            acc_d       = PAD_WORD;
            lane_cnt_d  = '0;
        end else if (accept) begin
            acc_d      = acc_fill;
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            acc_q        <= PAD_WORD;
            lane_cnt_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            lane_cnt_q   <= lane_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            word_count_q <= word_count_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_fifo_pack_writer.sv
// Directed self-checking bench for fifo_pack_writer (default parameters).
module tb_fifo_pack_writer;

    logic        write_clk = 1'b0;
    logic        write_rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        fifo_write_en;
    logic [63:0] fifo_write_data;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic [15:0] word_count;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          stalls = 0;
    int          clear_cyc;
    int          acc_at_clear;
    int          acc_cyc;
    logic [63:0] wq[$];
    int          wcyc[$];
    int          fdq[$];

    fifo_pack_writer #(
        .IN_WIDTH(16),
        .DATA_WIDTH(64),
        .RATIO(4),
        .PAD_VALUE(16'h0000),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .write_clk(write_clk),
        .write_rst_n(write_rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_last(s_last),
        .fifo_write_en(fifo_write_en),
        .fifo_write_data(fifo_write_data),
        .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .word_count(word_count),
        .frame_done(frame_done)
    );

    always #5 write_clk = ~write_clk;

    always @(posedge write_clk) cyc = cyc + 1;

    // Log every FIFO write and frame_done pulse; a write while full/almost-full is an error.
    always @(negedge write_clk) begin
        if (write_rst_n && fifo_write_en) begin
            wq.push_back(fifo_write_data);
            wcyc.push_back(cyc);
            n_cmp++;
            assert (fifo_full === 1'b0 && fifo_almost_full === 1'b0) else begin
                n_bad++;
                $error("FAIL write_gate observed full=%b afull=%b expected full=0 afull=0",
                       fifo_full, fifo_almost_full);
            end
        end
        if (write_rst_n && frame_done) fdq.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wq.delete();
        wcyc.delete();
        fdq.delete();
        stalls = 0;
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic beat(input logic [15:0] d, input logic last);
        logic rdy;
        int   n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            @(negedge write_clk);
            rdy = s_ready;
            @(posedge write_clk);
            #1;
            n++;
            if (!rdy) stalls++;
        end while (!rdy && n < 100);
        if (rdy) begin
            accepted++;
        end else begin
            n_cmp++;
            n_bad++;
            $error("FAIL beat_timeout observed=no_accept expected=accept data=%h", d);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(posedge write_clk);
        #1;
    endtask

    task automatic do_reset();
        write_rst_n = 1'b0;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        repeat (2) @(posedge write_clk);
        #1;
        write_rst_n = 1'b1;
    endtask

    initial begin
        write_rst_n      = 1'b0;
        s_valid          = 1'b0;
        s_data           = '0;
        s_last           = 1'b0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;

        // Reset values
        #2;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_wr_en", 64'(fifo_write_en), 64'd0);
        chk("rst_wr_data", fifo_write_data, 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        repeat (2) @(posedge write_clk);
        #1;
        write_rst_n = 1'b1;
        #1;
        chk("release_s_ready", 64'(s_ready), 64'd1);

        // Eight beats, always writable
        for (int i = 1; i <= 8; i++) beat(16'(i), 1'b0);
        idle(3);
        chk("t1_nwrites", 64'(wq.size()), 64'd2);
        chk("t1_word0", wq[0], 64'h0004_0003_0002_0001);
        chk("t1_word1", wq[1], 64'h0008_0007_0006_0005);
        chk("t1_word_count", 64'(word_count), 64'd2);
        chk("t1_stalls", 64'(stalls), 64'd0);
        chk("t1_no_frame_done", 64'(fdq.size()), 64'd0);

        // Short frame closed by s_last
        clear_logs();
        beat(16'h00A1, 1'b0);
        beat(16'h00A2, 1'b0);
        beat(16'h00A3, 1'b1);
        idle(3);
        chk("t2_nwrites", 64'(wq.size()), 64'd1);
        chk("t2_word", wq[0], 64'h0000_00A3_00A2_00A1);
        chk("t2_nframe_done", 64'(fdq.size()), 64'd1);
        chk("t2_frame_done_cyc", 64'(fdq[0]), 64'(wcyc[0] + 1));
        chk("t2_word_count", 64'(word_count), 64'd3);

        // almost_full held for 10 cycles while 8 beats are offered
        clear_logs();
        accepted = 0;
        fork
            begin
                fifo_almost_full = 1'b1;
                repeat (10) @(posedge write_clk);
                #2;
                acc_at_clear     = accepted;
                clear_cyc        = cyc;
                fifo_almost_full = 1'b0;
            end
            begin
                for (int i = 1; i <= 8; i++) beat(16'(16'h0010 + i), 1'b0);
            end
        join
        idle(3);
        chk("t3_accepted_while_afull", 64'(acc_at_clear), 64'd4);
        chk("t3_nwrites", 64'(wq.size()), 64'd2);
        chk("t3_first_write_cyc", 64'(wcyc[0]), 64'(clear_cyc));
        chk("t3_word0", wq[0], 64'h0014_0013_0012_0011);
        chk("t3_word1", wq[1], 64'h0018_0017_0016_0015);
        chk("t3_word_count", 64'(word_count), 64'd5);

        // Reset mid-word discards the partial word
        clear_logs();
        beat(16'h00E1, 1'b0);
        beat(16'h00E2, 1'b0);
        write_rst_n = 1'b0;
        #2;
        chk("t4_rst_word_count", 64'(word_count), 64'd0);
        chk("t4_rst_s_ready", 64'(s_ready), 64'd0);
        repeat (2) @(posedge write_clk);
        #1;
        write_rst_n = 1'b1;
        beat(16'h00B1, 1'b0);
        beat(16'h00B2, 1'b0);
        beat(16'h00B3, 1'b0);
        beat(16'h00B4, 1'b0);
        idle(3);
        chk("t4_nwrites", 64'(wq.size()), 64'd1);
        chk("t4_word", wq[0], 64'h00B4_00B3_00B2_00B1);
        chk("t4_word_count", 64'(word_count), 64'd1);

        // fifo_full alone blocks writes
        clear_logs();
        fifo_full = 1'b1;
        for (int i = 1; i <= 4; i++) beat(16'(16'h00D0 + i), 1'b0);
        idle(5);
        chk("t5_s_ready_full", 64'(s_ready), 64'd0);
        chk("t5_no_write_full", 64'(wq.size()), 64'd0);
        fifo_full = 1'b0;
        idle(2);
        chk("t5_nwrites", 64'(wq.size()), 64'd1);
        chk("t5_word", wq[0], 64'h00D4_00D3_00D2_00D1);

        // Single beat then idle
        clear_logs();
        beat(16'h00C1, 1'b0);
        acc_cyc = cyc;
        idle(200);
`ifdef FIFO_PACK_TIMEOUT_EN
        chk("t6_nwrites", 64'(wq.size()), 64'd1);
        chk("t6_word", wq[0], 64'h0000_0000_0000_00C1);
        chk("t6_write_cyc", 64'(wcyc[0]), 64'(acc_cyc + 65));
`else
        chk("t6_no_write", 64'(wq.size()), 64'd0);
        beat(16'h00C2, 1'b1);
        idle(3);
        chk("t6_nwrites", 64'(wq.size()), 64'd1);
        chk("t6_word", wq[0], 64'h0000_0000_00C2_00C1);
`endif

        // 70000 single-beat frames: word_count wraps
        do_reset();
        clear_logs();
        s_valid = 1'b1;
        s_last  = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            s_data = 16'(i);
            @(negedge write_clk);
            if (!s_ready) stalls++;
            @(posedge write_clk);
            #1;
        end
        idle(3);
        chk("t7_stalls", 64'(stalls), 64'd0);
        chk("t7_nwrites", 64'(wq.size()), 64'd70000);
        chk("t7_last_word", wq[69999], 64'h0000_0000_0000_116F);
        chk("t7_word_count", 64'(word_count), 64'd4464);
        chk("t7_nframe_done", 64'(fdq.size()), 64'd70000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
